// File: rtl/alarm_bank.sv
// -----------------------------------------------------------------------------
// alarm_bank
//   Multi-channel hh:mm alarm bank. Each of NUM_ALARMS channels holds a BCD
//   alarm time and an armed flag. Once per second every channel compares its
//   time with the running clock and, on a match, runs its own
//   IDLE / RINGING / SNOOZED state machine. Ringing times out after
//   RING_SECONDS ticks. A snooze returns to ringing after SNOOZE_SECONDS ticks.
//   Once MAX_SNOOZE snoozes have been used for a trigger, the next snooze
//   behaves as a dismiss.
//
// Optional build macro:
//   WEEKDAY_MASK_EN - adds a per-channel 7-bit weekday mask. When the macro is
//                     undefined, alarms match on every day.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tick_1hz     one-clk strobe, once per second
//   now_time     current time, BCD hh_mm_ss
//   set_en       programming strobe for channel set_idx
//   set_idx      channel to program; indices >= NUM_ALARMS are ignored
//   set_time     alarm time, BCD hh_mm
//   set_arm      armed flag, written together with set_time
//   weekday      (WEEKDAY_MASK_EN) current day 0..6; the value 7 never matches
//   set_daymask  (WEEKDAY_MASK_EN) day mask, written together with set_time
//   dismiss      pulse: stop every ringing or snoozed channel
//   snooze       pulse: snooze every ringing channel
//   ring         OR of ring_vec
//   ring_vec     per-channel ringing flag
//   armed_vec    per-channel armed flag
//   snoozed_vec  per-channel snoozed flag
//   active_idx   lowest ringing channel index, 0 when nothing rings
// -----------------------------------------------------------------------------
module alarm_bank #(
  parameter int NUM_ALARMS     = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic [23:0]           now_time,
  input  logic                  set_en,
  input  logic [2:0]            set_idx,
  input  logic [15:0]           set_time,
  input  logic                  set_arm,
`ifdef WEEKDAY_MASK_EN
  input  logic [2:0]            weekday,
  input  logic [6:0]            set_daymask,
`endif
  input  logic                  dismiss,
  input  logic                  snooze,
  output logic                  ring,
  output logic [NUM_ALARMS-1:0] ring_vec,
  output logic [NUM_ALARMS-1:0] armed_vec,
  output logic [NUM_ALARMS-1:0] snoozed_vec,
  output logic [2:0]            active_idx
);

  // A parameter value of 1 would give a zero-width counter, so each width is
  // held at a minimum of one bit.
  localparam int RCW = (RING_SECONDS > 1)   ? $clog2(RING_SECONDS)   : 1;
  localparam int SCW = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
  localparam int SNW = (MAX_SNOOZE > 0)     ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [RCW-1:0] RING_LAST   = RCW'(RING_SECONDS - 1);
  localparam logic [SCW-1:0] SNOOZE_LAST = SCW'(SNOOZE_SECONDS - 1);
  localparam logic [SNW-1:0] SNOOZE_MAX  = SNW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } chan_state_e;

  chan_state_e           state_q    [NUM_ALARMS];
  chan_state_e           state_d    [NUM_ALARMS];
  logic [15:0]           alarm_q    [NUM_ALARMS];
  logic [15:0]           alarm_d    [NUM_ALARMS];
  logic [RCW-1:0]        ring_cnt_q [NUM_ALARMS];
  logic [RCW-1:0]        ring_cnt_d [NUM_ALARMS];
  logic [SCW-1:0]        snz_cnt_q  [NUM_ALARMS];
  logic [SCW-1:0]        snz_cnt_d  [NUM_ALARMS];
  logic [SNW-1:0]        snz_num_q  [NUM_ALARMS];
  logic [SNW-1:0]        snz_num_d  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] armed_q;
  logic [NUM_ALARMS-1:0] armed_d;
  logic [NUM_ALARMS-1:0] set_hit;
  logic [NUM_ALARMS-1:0] match;
`ifdef WEEKDAY_MASK_EN
  logic [6:0]            mask_q     [NUM_ALARMS];
  logic [6:0]            mask_d     [NUM_ALARMS];
  logic [7:0]            day_bits;
`endif

  // Per-channel programming select and time match. Comparing set_idx against
  // each existing channel index is enough to ignore out-of-range indices.
  // The weekday mask is padded with a zero at bit 7, so weekday 7 never
  // matches.
  always_comb begin
    set_hit = '0;
    match   = '0;
`ifdef WEEKDAY_MASK_EN
    day_bits = 8'h00;
`endif
    for (int i = 0; i < NUM_ALARMS; i++) begin
      set_hit[i] = set_en && (set_idx == 3'(i));
      match[i]   = tick_1hz && armed_q[i] &&
                   (now_time[23:8] == alarm_q[i]) && (now_time[7:0] == 8'h00);
`ifdef WEEKDAY_MASK_EN
      day_bits = {1'b0, mask_q[i]};
      match[i] = match[i] && day_bits[weekday];
`endif
    end
  end

  // State register for every channel. Reset clears the times, the flags and
  // the counters, and returns all channels to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]    <= IDLE;
        alarm_q[i]    <= 16'h0000;
        ring_cnt_q[i] <= '0;
        snz_cnt_q[i]  <= '0;
        snz_num_q[i]  <= '0;
`ifdef WEEKDAY_MASK_EN
        mask_q[i]     <= 7'h7F;
`endif
      end
    end else begin
      armed_q <= armed_d;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]    <= state_d[i];
        alarm_q[i]    <= alarm_d[i];
        ring_cnt_q[i] <= ring_cnt_d[i];
        snz_cnt_q[i]  <= snz_cnt_d[i];
        snz_num_q[i]  <= snz_num_d[i];
`ifdef WEEKDAY_MASK_EN
        mask_q[i]     <= mask_d[i];
`endif
      end
    end
  end

  // Next-state logic for each channel. Programming the channel wins over
  // everything else, then dismiss, then snooze, then tick-driven
  // timeout/expiry, and finally a new match from IDLE. A match while the
  // channel is RINGING or SNOOZED is ignored, so there is no retrigger.
  // Counters stop at their last value and never wrap.
  always_comb begin
    armed_d = armed_q;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      state_d[i]    = state_q[i];
      alarm_d[i]    = alarm_q[i];
      ring_cnt_d[i] = ring_cnt_q[i];
      snz_cnt_d[i]  = snz_cnt_q[i];
      snz_num_d[i]  = snz_num_q[i];
`ifdef WEEKDAY_MASK_EN
      mask_d[i]     = mask_q[i];
`endif
      if (set_hit[i]) begin
        alarm_d[i]    = set_time;
        armed_d[i]    = set_arm;
        state_d[i]    = IDLE;
        ring_cnt_d[i] = '0;
        snz_cnt_d[i]  = '0;
        snz_num_d[i]  = '0;
`ifdef WEEKDAY_MASK_EN
        mask_d[i]     = set_daymask;
`endif
      end else begin
        case (state_q[i])
          IDLE: begin
            if (match[i]) begin
              state_d[i]    = RINGING;
              ring_cnt_d[i] = '0;
              snz_num_d[i]  = '0;
            end
          end
          RINGING: begin
            if (dismiss) begin
              state_d[i] = IDLE;
            end else if (snooze) begin
              if (snz_num_q[i] < SNOOZE_MAX) begin
                state_d[i]   = SNOOZED;
                snz_cnt_d[i] = '0;
                snz_num_d[i] = snz_num_q[i] + SNW'(1);
              end else begin
                state_d[i] = IDLE;
              end
            end else if (tick_1hz) begin
              if (ring_cnt_q[i] == RING_LAST) begin
                state_d[i] = IDLE;
              end else begin
                ring_cnt_d[i] = ring_cnt_q[i] + RCW'(1);
              end
            end
          end
          SNOOZED: begin
            if (dismiss) begin
              state_d[i] = IDLE;
            end else if (tick_1hz) begin
              if (snz_cnt_q[i] == SNOOZE_LAST) begin
                state_d[i]    = RINGING;
                ring_cnt_d[i] = '0;
              end else begin
                snz_cnt_d[i] = snz_cnt_q[i] + SCW'(1);
              end
            end
          end
          default: begin
            state_d[i] = IDLE;
          end
        endcase
      end
    end
  end

  // Outputs are decoded straight from the state registers. active_idx is
  // found by scanning from the highest index down, so the lowest ringing
  // channel is the one left in active_idx.
  always_comb begin
    ring_vec    = '0;
    snoozed_vec = '0;
    active_idx  = 3'd0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      ring_vec[i]    = (state_q[i] == RINGING);
      snoozed_vec[i] = (state_q[i] == SNOOZED);
    end
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ring_vec[i]) begin
        active_idx = 3'(i);
      end
    end
    ring      = |ring_vec;
    armed_vec = armed_q;
  end

endmodule
